bcd_to_bin: RTL and testbench
=============================

// Module: bcd_to_bin
// PURPOSE
//  Sequential BCD-to-binary converter, the inverse of the timer's binary-to-BCD path.
//  Takes IN_DECADES packed BCD digits, e.g. a time preset entered on BCD switches or keypad digits.
//  Returns the binary value for the countdown counter.
//  Iterative Horner scheme: acc = acc*10 + digit, one decade per enabled clock, MS decade first.
//  START/BUSY/DONE handshake; result register holds its value between conversions.
// PARAMETERS
//  IN_DECADES    4                Number of BCD decades at input (1..8).
//  OUT_BITS_NUM  14               Width of binary result Q (14 covers 9999).
//  IN_BITS_NUM   IN_DECADES*4     Derived input width; do not override.
// PORTS
//  CLK    in   1               Clock, rising edge.
//  CLR    in   1               Reset, asynchronous, active-high.
//  CE     in   1               Clock enable; all state advance gated by CE (except DONE clear).
//  START  in   1               Conversion request; sampled only in IDLE with CE=1.
//  IN     in   IN_BITS_NUM     Packed BCD, IN[3:0] = units decade; captured on accepted START.
//  BUSY   out  1               High while conversion in progress.
//  DONE   out  1               One-CLK pulse: Q/ERR/OVF updated this cycle.
//  Q      out  OUT_BITS_NUM    Binary result; holds until next completion.
//  ERR    out  1               Last conversion contained a digit > 9.
//  OVF    out  1               Last conversion exceeded 2^OUT_BITS_NUM-1.
// BEHAVIOUR
//  Reset: state=IDLE, BUSY=0, DONE=0, Q=0, ERR=0, OVF=0, acc/shift/counter=0. CLR mid-conversion aborts, no DONE.
//  States: IDLE -> CONV on (START & CE); CONV -> IDLE after IN_DECADES enabled cycles.
//  Accept edge (E0): shift<=IN, acc<=0, cnt<=IN_DECADES-1, err/ovf flags<=0, BUSY<=1.
//  Each CE edge in CONV: d=shift[MSB-:4]; acc<=acc*10+d (arith in OUT_BITS_NUM+4 bits);
//   shift<<=4; err|=(d>9); ovf|=(result>2^OUT_BITS_NUM-1); cnt-=1.
//  Edge where cnt==0 is processed: Q<=final acc, ERR/OVF<=flags, DONE<=1, BUSY<=0, state<=IDLE.
//  Latency: with CE held 1, DONE high exactly IN_DECADES cycles after the accept edge.
//  CE=0 in CONV: freeze everything; latency extends by the number of stalled cycles.
//  DONE deasserts on the next CLK edge regardless of CE.
//  START while BUSY: ignored, IN not re-sampled. START in DONE cycle: accepted (state already IDLE).
//  Invalid digit (10..15): used at face value in the MAC; ERR reports it; no abort.
//  All-zero input -> Q=0, ERR=0, OVF=0.
// CONFIGURATION
//  Macro BCD_TO_BIN_SAT_EN:
//   defined   -> on overflow, acc clamps to 2^OUT_BITS_NUM-1 at the step it occurs and stays clamped;
//                Q = all ones.
//   undefined -> acc wraps mod 2^OUT_BITS_NUM each step; Q = true value mod 2^OUT_BITS_NUM.
//  OVF is reported identically in both builds.
// STRUCTURE
//  Package bcd_pkg:
//   BCD_DIGIT_W=4, BCD_MAX_DIGIT=4'd9.
//   State enum {ST_IDLE, ST_CONV}.
//   Helper function for counter width $clog2(IN_DECADES).
//  Sub-module bcd_digit_mac (combinational): acc, digit -> next_acc, ovf, bad_digit.
//   Holds the saturate/wrap choice under BCD_TO_BIN_SAT_EN.
//  Top holds FSM, shift register, counter, output registers.
// TESTING
//  1) IN=16'h1234, START 1 cycle, CE=1 -> DONE 4 cycles after accept, Q=1234, ERR=0, OVF=0, BUSY low with DONE.
//  2) IN=16'h9999 -> Q=9999; then IN=16'h0000 -> Q=0; Q holds 9999 between the two DONEs.
//  3) CE toggled 1/0 during IN=16'h0507 -> DONE after 4 enabled edges (8 clocks), Q=507.
//  4) IN=16'h12A4 -> DONE, ERR=1, Q=1*1000+2*100+10*10+4=1304.
//  5) OUT_BITS_NUM=10, IN=16'h2048 -> OVF=1; SAT_EN build Q=1023; else Q=2048 mod 1024=0.
//  6) CLR pulsed at 2nd conversion cycle -> all outputs 0, no DONE; START then IN=16'h0042 -> Q=42.
//  7) START held high across a whole conversion -> next conversion accepted in DONE cycle; IN re-sampled only there.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared definitions for the sequential BCD-to-binary converter:
//            digit width, largest legal BCD digit, FSM state encoding and a
//            helper that sizes the decade counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Decade counter width; a single-decade build still needs one bit.
  function automatic int cnt_width(input int decades);
    return (decades > 1) ? $clog2(decades) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_mac.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_mac
// Purpose  : One Horner step of the BCD-to-binary conversion:
//            next_acc = acc*10 + digit, with overflow and bad-digit detect.
//            Build option BCD_TO_BIN_SAT_EN selects saturating (clamp to all
//            ones) instead of wrapping behaviour on overflow.
// Ports    : acc       in  OUT_BITS_NUM  running accumulator
//            digit     in  4             current BCD decade (face value used)
//            next_acc  out OUT_BITS_NUM  updated accumulator
//            ovf       out 1             step result exceeded 2^OUT_BITS_NUM-1
//            bad_digit out 1             digit above 9
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int OUT_BITS_NUM = 14
) (
  input  logic [OUT_BITS_NUM-1:0] acc,
  input  logic [BCD_DIGIT_W-1:0]  digit,
  output logic [OUT_BITS_NUM-1:0] next_acc,
  output logic                    ovf,
  output logic                    bad_digit
);

  // Four extra bits hold 10*(2^W-1)+15 without loss.
  localparam int PW = OUT_BITS_NUM + BCD_DIGIT_W;

  logic [PW-1:0] w_full;

  assign w_full    = ({{BCD_DIGIT_W{1'b0}}, acc} * PW'(10)) + PW'(digit);
  assign ovf       = |w_full[PW-1:OUT_BITS_NUM];
  assign bad_digit = (digit > BCD_MAX_DIGIT);

`ifdef BCD_TO_BIN_SAT_EN
  // Once clamped, every later step overflows again, so the clamp sticks.
  assign next_acc = ovf ? {OUT_BITS_NUM{1'b1}} : w_full[OUT_BITS_NUM-1:0];
`else
  assign next_acc = w_full[OUT_BITS_NUM-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Purpose  : Sequential BCD-to-binary converter (Horner scheme, one decade
//            per enabled clock, most significant decade first) with a
//            START/BUSY/DONE handshake. Result registers hold between runs.
//            Build option BCD_TO_BIN_SAT_EN: saturate instead of wrap.
// Ports    : CLK   in  1             clock, rising edge
//            CLR   in  1             asynchronous active-high reset
//            CE    in  1             clock enable (DONE clears regardless)
//            START in  1             conversion request, sampled in IDLE
//            IN    in  IN_BITS_NUM   packed BCD, IN[3:0] = units
//            BUSY  out 1             conversion in progress
//            DONE  out 1             one-cycle completion pulse
//            Q     out OUT_BITS_NUM  binary result
//            ERR   out 1             last conversion saw a digit > 9
//            OVF   out 1             last conversion overflowed Q
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int IN_DECADES   = 4,
  parameter int OUT_BITS_NUM = 14,
  parameter int IN_BITS_NUM  = IN_DECADES * 4
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    CE,
  input  logic                    START,
  input  logic [IN_BITS_NUM-1:0]  IN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [OUT_BITS_NUM-1:0] Q,
  output logic                    ERR,
  output logic                    OVF
);

  localparam int CNT_W = cnt_width(IN_DECADES);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IN_BITS_NUM-1:0]  r_shift;
  logic [OUT_BITS_NUM-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;
  logic                    r_ovf;

  logic                    w_accept;
  logic                    w_step;
  logic                    w_last;
  logic [BCD_DIGIT_W-1:0]  w_digit;
  logic [OUT_BITS_NUM-1:0] w_next_acc;
  logic                    w_step_ovf;
  logic                    w_bad_digit;

  assign w_accept = (r_state == ST_IDLE) && START && CE;
  assign w_step   = (r_state == ST_CONV) && CE;
  assign w_last   = w_step && (r_cnt == '0);
  assign w_digit  = r_shift[IN_BITS_NUM-1 -: BCD_DIGIT_W];
  assign BUSY     = (r_state == ST_CONV);

  bcd_digit_mac #(
    .OUT_BITS_NUM (OUT_BITS_NUM)
  ) u_mac (
    .acc       (r_acc),
    .digit     (w_digit),
    .next_acc  (w_next_acc),
    .ovf       (w_step_ovf),
    .bad_digit (w_bad_digit)
  );

  // State register
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_CONV;
      ST_CONV: if (w_last)   w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      DONE    <= 1'b0;
      Q       <= '0;
      ERR     <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      // The completion pulse lasts one clock even when CE is low next cycle.
      DONE <= 1'b0;
      if (w_accept) begin
        r_shift <= IN;
        r_acc   <= '0;
        r_cnt   <= CNT_W'(IN_DECADES - 1);
        r_err   <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (w_step) begin
        r_shift <= r_shift << BCD_DIGIT_W;
        r_acc   <= w_next_acc;
        r_cnt   <= r_cnt - 1'b1;
        r_err   <= r_err | w_bad_digit;
        r_ovf   <= r_ovf | w_step_ovf;
        if (w_last) begin
          // Publish this step's values directly; the flag registers lag by one.
          Q    <= w_next_acc;
          ERR  <= r_err | w_bad_digit;
          OVF  <= r_ovf | w_step_ovf;
          DONE <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Purpose  : Self-checking bench for bcd_to_bin. Two instances share stimulus:
//            a 14-bit result build and a 10-bit build that exercises overflow.
//            Expected results come from the decimal value of the BCD word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        CE = 1'b0;
  logic        START = 1'b0;
  logic [15:0] IN = '0;

  logic        BUSY, DONE, ERR, OVF;
  logic [13:0] Q;
  logic        BUSY_s, DONE_s, ERR_s, OVF_s;
  logic [9:0]  Q_s;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_q = 0;

  always #5 CLK = ~CLK;

  bcd_to_bin #(.IN_DECADES(4), .OUT_BITS_NUM(14)) u_dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .START(START), .IN(IN),
    .BUSY(BUSY), .DONE(DONE), .Q(Q), .ERR(ERR), .OVF(OVF)
  );

  bcd_to_bin #(.IN_DECADES(4), .OUT_BITS_NUM(10)) u_dut_s (
    .CLK(CLK), .CLR(CLR), .CE(CE), .START(START), .IN(IN),
    .BUSY(BUSY_s), .DONE(DONE_s), .Q(Q_s), .ERR(ERR_s), .OVF(OVF_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Decimal value of the BCD word (digits at face value), then reduced to w bits.
  task automatic ref_model(input logic [15:0] bcd, input int w,
                           output logic [31:0] q, output logic err, output logic ovf);
    int unsigned val, p, d, mx;
    val = 0; p = 1; err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = (32'(bcd) >> (4 * k)) & 32'd15;
      val += d * p;
      p *= 10;
      if (d > 9) err = 1'b1;
    end
    mx  = (32'd1 << w) - 1;
    ovf = (val > mx);
`ifdef BCD_TO_BIN_SAT_EN
    q = ovf ? mx : val;
`else
    q = val % (mx + 1);
`endif
  endtask

  // ce_mode: 0 = CE held high, 1 = CE toggles 0/1, 2 = random stalls
  task automatic do_conv(input logic [15:0] bcd, input int ce_mode);
    logic [31:0] eq, eq_s;
    logic ee, eo, ee_s, eo_s, cur;
    int en, cyc;
    ref_model(bcd, 14, eq, ee, eo);
    ref_model(bcd, 10, eq_s, ee_s, eo_s);
    IN = bcd; START = 1'b1; CE = 1'b1;
    tick();
    START = 1'b0;
    IN = 16'($urandom);
    check("busy_after_accept", BUSY, 1);
    en = 0; cyc = 0;
    while (en < 4 && cyc < 64) begin
      case (ce_mode)
        0:       CE = 1'b1;
        1:       CE = cyc[0];
        default: CE = ($urandom_range(0, 2) != 0);
      endcase
      cur = CE;
      tick();
      cyc++;
      if (cur) en++;
      if (en < 4) begin
        check("done_early", DONE, 0);
        check("q_hold_busy", Q, last_q);
      end
    end
    if (en < 4) check("done_timeout", 0, 1);
    if (ce_mode == 0) check("latency_ce1", cyc, 4);
    if (ce_mode == 1) check("latency_toggle", cyc, 8);
    check("done", DONE, 1);
    check("busy_low_at_done", BUSY, 0);
    check("q", Q, eq);
    check("err", ERR, ee);
    check("ovf", OVF, eo);
    check("q_small", Q_s, eq_s);
    check("err_small", ERR_s, ee_s);
    check("ovf_small", OVF_s, eo_s);
    last_q = eq;
    CE = 1'b0;
    tick();
    check("done_clears_ce0", DONE, 0);
    check("q_holds", Q, eq);
  endtask

  initial begin
    logic [15:0] r;
    // Reset state
    #2;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_q", Q, 0);
    check("rst_err", ERR, 0);
    check("rst_ovf", OVF, 0);
    tick();
    CLR = 1'b0;
    tick();

    do_conv(16'h1234, 0);
    do_conv(16'h9999, 0);
    do_conv(16'h0000, 0);
    do_conv(16'h0507, 1);
    do_conv(16'h2048, 0);
    do_conv(16'h12A4, 0);

    // Abort mid-conversion with CLR
    IN = 16'h5555; START = 1'b1; CE = 1'b1;
    tick();
    START = 1'b0;
    tick();
    CLR = 1'b1;
    #1;
    check("clr_busy", BUSY, 0);
    check("clr_q", Q, 0);
    check("clr_err", ERR, 0);
    check("clr_ovf_small", OVF_s, 0);
    check("clr_done", DONE, 0);
    CLR = 1'b0;
    last_q = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_done_after_clr", DONE, 0);
    end
    do_conv(16'h0042, 0);

    // START held across a conversion: accepted again in the DONE cycle only
    IN = 16'h0321; START = 1'b1; CE = 1'b1;
    tick();
    IN = 16'h0999;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        tick();
        check("hold_done_early", DONE, 0);
      end else begin
        tick();
      end
    end
    check("hold_done1", DONE, 1);
    check("hold_q1", Q, 321);
    IN = 16'h0876;
    tick();
    check("hold_reaccept_busy", BUSY, 1);
    check("hold_done_clear", DONE, 0);
    START = 1'b0;
    IN = 16'h0111;
    tick(); tick(); tick(); tick();
    check("hold_done2", DONE, 1);
    check("hold_q2", Q, 876);
    last_q = 876;
    CE = 1'b0;
    tick();

    // Randomized conversions with random stalls
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 4; k++) begin
        r[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      end
      do_conv(r, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
